cordic_elemet: RTL and testbench

CORDIC_ELEMET -- requirements
Module: cordic_elemet

---
 rtl/cordic_elemet.sv | 57 +++++
 tb/tb_cordic_elemet.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cordic_elemet.sv
// One rotation-mode CORDIC micro-rotation stage; chain ORDER=0,1,2,... for a full rotator.
// One CLK of latency, accepts a new input every cycle, no flow control (never stalls).
module cordic_elemet #(
    parameter int                       ADDRESS_WIDTH = 14,
    parameter int                       VALUE_WIDTH   = 14,
    parameter logic [ADDRESS_WIDTH-1:0] e_k           = 14'h3243,
    parameter int                       ORDER         = 0
) (
    input  logic                     CLK,
    input  logic                     RESET_n,
    input  logic [VALUE_WIDTH:0]     x_k,
    input  logic [VALUE_WIDTH:0]     y_k,
    input  logic [ADDRESS_WIDTH:0]   z_k,
    output logic [VALUE_WIDTH:0]     x_k1,
    output logic [VALUE_WIDTH:0]     y_k1,
    output logic [ADDRESS_WIDTH:0]   z_k1
);

    logic [VALUE_WIDTH:0]   x_sh;
    logic [VALUE_WIDTH:0]   y_sh;
    logic [VALUE_WIDTH:0]   x_nxt;
    logic [VALUE_WIDTH:0]   y_nxt;
    logic [ADDRESS_WIDTH:0] e_ext;
    logic [ADDRESS_WIDTH:0] z_nxt;
    logic                   rot_neg;

    // Sign-preserving shifts; shifted-out bits are simply dropped.
    assign x_sh    = $signed(x_k) >>> ORDER;
    assign y_sh    = $signed(y_k) >>> ORDER;
    assign e_ext   = {1'b0, e_k};
    assign rot_neg = z_k[ADDRESS_WIDTH];

    always_comb begin
        x_nxt = x_k - y_sh;
        y_nxt = y_k + x_sh;
        z_nxt = z_k - e_ext;
        if (rot_neg) begin
            x_nxt = x_k + y_sh;
            y_nxt = y_k - x_sh;
            z_nxt = z_k + e_ext;
        end
    end

    // RESET_n is active-high despite its name.
    always_ff @(posedge CLK or posedge RESET_n) begin
        if (RESET_n) begin
            x_k1 <= '0;
            y_k1 <= '0;
            z_k1 <= '0;
        end else begin
            x_k1 <= x_nxt;
            y_k1 <= y_nxt;
            z_k1 <= z_nxt;
        end
    end

endmodule

// File: tb/tb_cordic_elemet.sv
// Directed + randomized bench for cordic_elemet: three standalone stages (ORDER 0..2)
// checked through an expectation queue, plus a 13-stage rotator chain.
module tb_cordic_elemet;

    typedef struct {
        int          unit;
        logic [14:0] x;
        logic [14:0] y;
        logic [14:0] z;
        string       tag;
    } exp_t;

    logic        CLK;
    logic        RESET_n;
    logic [14:0] ux [0:2];
    logic [14:0] uy [0:2];
    logic [14:0] uz [0:2];
    logic [14:0] ox [0:2];
    logic [14:0] oy [0:2];
    logic [14:0] oz [0:2];
    logic [14:0] chain_x, chain_y, chain_z;
    logic [14:0] cx [0:13];
    logic [14:0] cy [0:13];
    logic [14:0] cz [0:13];

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic logic [13:0] ek_of(input int k);
        case (k)
            0:       ek_of = 14'h3243;
            1:       ek_of = 14'h1DAC;
            2:       ek_of = 14'h0FAD;
            3:       ek_of = 14'h07F5;
            4:       ek_of = 14'h03FE;
            5:       ek_of = 14'h01FF;
            6:       ek_of = 14'h00FF;
            7:       ek_of = 14'h007F;
            8:       ek_of = 14'h003F;
            9:       ek_of = 14'h001F;
            10:      ek_of = 14'h000F;
            11:      ek_of = 14'h0007;
            12:      ek_of = 14'h0003;
            default: ek_of = 14'h0000;
        endcase
    endfunction

    cordic_elemet #(.ADDRESS_WIDTH(14), .VALUE_WIDTH(14), .e_k(14'h3243), .ORDER(0)) u_s0 (
        .CLK(CLK), .RESET_n(RESET_n), .x_k(ux[0]), .y_k(uy[0]), .z_k(uz[0]),
        .x_k1(ox[0]), .y_k1(oy[0]), .z_k1(oz[0]));
    cordic_elemet #(.ADDRESS_WIDTH(14), .VALUE_WIDTH(14), .e_k(14'h1DAC), .ORDER(1)) u_s1 (
        .CLK(CLK), .RESET_n(RESET_n), .x_k(ux[1]), .y_k(uy[1]), .z_k(uz[1]),
        .x_k1(ox[1]), .y_k1(oy[1]), .z_k1(oz[1]));
    cordic_elemet #(.ADDRESS_WIDTH(14), .VALUE_WIDTH(14), .e_k(14'h0FAD), .ORDER(2)) u_s2 (
        .CLK(CLK), .RESET_n(RESET_n), .x_k(ux[2]), .y_k(uy[2]), .z_k(uz[2]),
        .x_k1(ox[2]), .y_k1(oy[2]), .z_k1(oz[2]));

    assign cx[0] = chain_x;
    assign cy[0] = chain_y;
    assign cz[0] = chain_z;

    for (genvar g = 0; g < 13; g++) begin : g_chain
        cordic_elemet #(.ADDRESS_WIDTH(14), .VALUE_WIDTH(14), .e_k(ek_of(g)), .ORDER(g)) u_stage (
            .CLK(CLK), .RESET_n(RESET_n), .x_k(cx[g]), .y_k(cy[g]), .z_k(cz[g]),
            .x_k1(cx[g+1]), .y_k1(cy[g+1]), .z_k1(cz[g+1]));
    end

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: got 0x%h, expected 0x%h", tag, got, want);
        end
    endtask

    task automatic chk_tol(input string tag, input logic [14:0] got, input logic [14:0] want);
        int d;
        d = int'($signed(got)) - int'($signed(want));
        vectors++;
        assert (d >= -16 && d <= 16) else begin
            miscompares++;
            $error("FAIL %s: got 0x%h, expected 0x%h +-16", tag, got, want);
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("%s.u%0d.x", tag, u), ox[u], 15'h0000);
            chk($sformatf("%s.u%0d.y", tag, u), oy[u], 15'h0000);
            chk($sformatf("%s.u%0d.z", tag, u), oz[u], 15'h0000);
        end
    endtask

    task automatic drive(input int u, input logic [14:0] x, input logic [14:0] y,
                         input logic [14:0] z, input logic [14:0] ex, input logic [14:0] ey,
                         input logic [14:0] ez, input string tag);
        exp_t e;
        ux[u] = x;
        uy[u] = y;
        uz[u] = z;
        e.unit = u;
        e.x    = ex;
        e.y    = ey;
        e.z    = ez;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    // Reference micro-rotation for unit u (ORDER = u).
    task automatic drive_model(input int u, input logic [14:0] x, input logic [14:0] y,
                               input logic [14:0] z, input string tag);
        logic [14:0] xsh, ysh, ee, ex, ey, ez;
        xsh = $signed(x) >>> u;
        ysh = $signed(y) >>> u;
        ee  = {1'b0, ek_of(u)};
        if (z[14]) begin
            ex = x + ysh;
            ey = y - xsh;
            ez = z + ee;
        end else begin
            ex = x - ysh;
            ey = y + xsh;
            ez = z - ee;
        end
        drive(u, x, y, z, ex, ey, ez, tag);
    endtask

    task automatic settle();
        exp_t e;
        @(posedge CLK);
        #1;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, ".x"}, ox[e.unit], e.x);
            chk({e.tag, ".y"}, oy[e.unit], e.y);
            chk({e.tag, ".z"}, oz[e.unit], e.z);
        end
    endtask

    initial begin
        RESET_n = 1'b1;
        for (int u = 0; u < 3; u++) begin
            ux[u] = '0;
            uy[u] = '0;
            uz[u] = '0;
        end
        chain_x = '0;
        chain_y = '0;
        chain_z = '0;

        #2;
        chk_zero("reset_async");
        @(posedge CLK);
        #1;
        chk_zero("reset_held");

        drive(0, 15'h1000, 15'h0000, 15'h0000, 15'h1000, 15'h1000, 15'h4DBD, "s0_basic");
        drive(1, 15'h2000, 15'h1000, 15'h7000, 15'h2800, 15'h0000, 15'h0DAC, "s1_negz");
        drive(2, 15'h0000, 15'h7FFC, 15'h0000, 15'h0001, 15'h7FFC, 15'h7053, "s2_ashift");
        #1;
        RESET_n = 1'b0;
        settle();

        drive(0, 15'h3FFF, 15'h3FFF, 15'h0000, 15'h0000, 15'h7FFE, 15'h4DBD, "s0_wrap");
        settle();

        for (int i = 0; i < 6; i++) begin
            for (int u = 0; u < 3; u++) begin
                drive_model(u, 15'($urandom), 15'($urandom), 15'($urandom),
                            $sformatf("rnd%0d.u%0d", i, u));
            end
            settle();
        end

        drive(0, 15'h1000, 15'h0000, 15'h0000, 15'h1000, 15'h1000, 15'h4DBD, "s0_pre_rst");
        settle();
        #2;
        RESET_n = 1'b1;
        #1;
        chk_zero("midrst_async");
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK);
            #1;
            chk_zero($sformatf("midrst_hold%0d", c));
        end
        drive(0, 15'h3FFF, 15'h3FFF, 15'h0000, 15'h0000, 15'h7FFE, 15'h4DBD, "s0_post_rst");
        #1;
        RESET_n = 1'b0;
        settle();

        chain_x = 15'h26DD;
        chain_y = 15'h0000;
        chain_z = 15'h2183;
        repeat (13) @(posedge CLK);
        #1;
        chk_tol("chain.cos", cx[13], 15'h376D);
        chk_tol("chain.sin", cy[13], 15'h2000);
        chk_tol("chain.z",   cz[13], 15'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
